turn_signal_seq: RTL and testbench
==================================

Name: turn_signal_seq

Overview:
- Parametrised sequential turn-signal/tail-light controller with NLAMP lamps per side.
- Runs a thermometer sweep (1, 2, …, NLAMP lamps lit) on the left side, the right side, or both (hazard).
- Each sweep step is held for TICK_DIV clock cycles.
- Sits between debounced switch inputs and the lamp drivers on the lab board.

Parameters:
- NLAMP, 3, lamps per side (≥1).
- TICK_DIV, 1, clock cycles each sweep step is held (≥1); 1 means one step per clock.
- CW, $clog2(TICK_DIV+1), prescaler counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- left  in  1  left-turn request, level.
- right  in  1  right-turn request, level.
- hazard  in  1  hazard request, level.
- brake  in  1  brake request, level (exists only with TSEQ_BRAKE_EN).
- lamp_l  out  NLAMP  left lamps; bit 0 = innermost.
- lamp_r  out  NLAMP  right lamps; bit 0 = innermost.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Registers: state {IDLE, LEFT, RIGHT, HAZ}, step[$clog2(NLAMP+1)-1:0], presc[CW-1:0].
- Reset is asynchronous, clock is clk. On reset: state=IDLE, step=0, presc=0. All outputs 0 while reset is high and on the first cycle after release.
- Moore outputs, decoded combinationally from registers only; no input-to-output path.
- Lamp decode: lamp bit k is lit iff k < step on each active side. LEFT drives lamp_l, RIGHT drives lamp_r, HAZ drives both identically. The inactive side is 0.
- IDLE: inputs are sampled on every clock edge, with priority:
  - hazard, or (left & right) → HAZ
  - left → LEFT
  - right → RIGHT
  - none → stay in IDLE.
  - On entry to any sweep state: step=1, presc=0. The first lamp lights the cycle after the request is sampled (1-cycle latency).
- LEFT/RIGHT/HAZ:
  - presc increments each cycle.
  - When presc==TICK_DIV-1: presc←0 and a tick occurs.
  - On a tick with step<NLAMP: step←step+1.
  - On a tick with step==NLAMP: state←IDLE, step←0.
  - Each pattern is held exactly TICK_DIV cycles, so a full sweep occupies NLAMP·TICK_DIV cycles.
  - IDLE lasts at least 1 cycle between sweeps. With a request held continuously, the period is NLAMP·TICK_DIV+1 cycles.
- Inputs are ignored mid-sweep. A request dropped mid-sweep still completes the sweep. A side switch or new hazard takes effect only from IDLE.
- Reset mid-sweep returns immediately to IDLE with all lamps dark.
- NLAMP=1: single-step sweep. TICK_DIV=1: tick on every cycle; presc is constant 0.
- Illegal state encodings decode to all-zero outputs and go to IDLE on the next edge.

Optional Feature:
- Macro: TSEQ_BRAKE_EN.
- Defined:
  - brake port exists.
  - While brake=1, any side not driven by a LEFT/RIGHT sweep shows all NLAMP lamps lit, combinationally from the registered brake_q (1-cycle latency).
  - In IDLE with brake=1, both sides are fully lit.
  - In HAZ, brake is ignored.
  - busy is unaffected by brake.
  - brake_q resets to 0.
- Undefined: no brake port, no brake_q register; behaviour is exactly as above.

Decomposition:
- Package tseq_pkg: state enum tseq_state_t (logic [1:0]: IDLE=0, LEFT=1, RIGHT=2, HAZ=3) and a function thermo(step) returning the NLAMP-bit mask.
- Sub-module tseq_prescaler(clk, reset, clr, tick) holds presc and the TICK_DIV compare. The FSM asserts clr on sweep entry.

Test Plan:
- NLAMP=3, TICK_DIV=1: reset, hold left=1 → lamp_l 001, 011, 111, 000, 001, …; period 4 cycles; lamp_r stays 000.
- NLAMP=4, TICK_DIV=3: pulse right for 1 cycle → lamp_r 0001 for 3 cycles, then 0011, 0111, 1111 for 3 cycles each, then 0000; busy high for exactly 12 cycles.
- left=1 and right=1 together (also repeated with hazard=1 alone) → lamp_l==lamp_r through 001, 011, 111.
- During a LEFT sweep at step 2, raise right=1 → left sweep completes. Next sweep is HAZ if left is still high, otherwise RIGHT.
- Assert reset at step 2 of a HAZ sweep with TICK_DIV=2 → outputs 000/000 and busy=0 immediately; after release, the first sweep restarts at step 1 with a full TICK_DIV hold.
- TSEQ_BRAKE_EN defined, NLAMP=3: brake=1 and left=1 → lamp_r=111 throughout while lamp_l sweeps. Then brake=1 and hazard=1 → both sides sweep, brake ignored.

Source files
------------

// File: rtl/tseq_pkg.sv
// Shared types and helpers for the sequential turn-signal controller.
// The state encoding is fixed so that lamp and busy decode logic can rely on it.
package tseq_pkg;

  // Widest lamp bank the thermometer helper can describe.
  localparam int unsigned MAXLAMP = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } tseq_state_t;

  // Thermometer mask: bit k is set iff k < step. Callers cast it down to their bank width.
  function automatic logic [MAXLAMP-1:0] thermo(input int unsigned step);
    logic [MAXLAMP-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < MAXLAMP; k++) begin
      m[k] = (k < step);
    end
    return m;
  endfunction

endpackage

// File: rtl/tseq_prescaler.sv
// Step-hold prescaler: counts clock cycles within one sweep step and pulses
// tick on the last cycle of each TICK_DIV-cycle hold. clr parks the counter at 0.
module tseq_prescaler #(
  parameter int TICK_DIV = 1,
  localparam int CW = $clog2(TICK_DIV + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] presc;

  assign tick = (presc == LAST);

  // Hold counter: cleared while the sequencer waits, wraps to 0 on each tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (clr || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/turn_signal_seq.sv
// Sequential turn-signal / tail-light controller with NLAMP lamps per side.
// Optional brake input is enabled by defining TSEQ_BRAKE_EN; the default build
// has no brake port and no brake register.
module turn_signal_seq
  import tseq_pkg::*;
#(
  parameter int NLAMP    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
`ifdef TSEQ_BRAKE_EN
  input  logic             brake,
`endif
  output logic [NLAMP-1:0] lamp_l,
  output logic [NLAMP-1:0] lamp_r,
  output logic             busy
);

  localparam int SW = $clog2(NLAMP + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(NLAMP);

  tseq_state_t   state, state_next;
  logic [SW-1:0] step, step_next;
  logic          tick;
  logic          clr;
  logic [NLAMP-1:0] mask;

  // Prescaler sits at 0 while idle so every sweep starts with a full hold.
  assign clr = (state == IDLE);

  tseq_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // State and step registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

`ifdef TSEQ_BRAKE_EN
  logic brake_q;

  // Registered brake request; lamps respond one cycle after the switch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brake_q <= 1'b0;
    end else begin
      brake_q <= brake;
    end
  end
`endif

  // Next-state: requests are only accepted from IDLE; sweeps always run to completion.
  always_comb begin
    state_next = IDLE;
    step_next  = '0;
    case (state)
      IDLE: begin
        if (hazard || (left && right)) begin
          state_next = HAZ;
          step_next  = SW'(1);
        end else if (left) begin
          state_next = LEFT;
          step_next  = SW'(1);
        end else if (right) begin
          state_next = RIGHT;
          step_next  = SW'(1);
        end
      end
      LEFT, RIGHT, HAZ: begin
        state_next = state;
        step_next  = step;
        if (tick) begin
          if (step < LAST_STEP) begin
            step_next = step + 1'b1;
          end else begin
            state_next = IDLE;
            step_next  = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        step_next  = '0;
      end
    endcase
  end

  // Moore lamp decode from registers only; brake fills any side not swept by LEFT/RIGHT.
  always_comb begin
    mask   = NLAMP'(thermo(32'(step)));
    lamp_l = '0;
    lamp_r = '0;
    busy   = 1'b0;
    case (state)
      LEFT: begin
        lamp_l = mask;
        busy   = 1'b1;
      end
      RIGHT: begin
        lamp_r = mask;
        busy   = 1'b1;
      end
      HAZ: begin
        lamp_l = mask;
        lamp_r = mask;
        busy   = 1'b1;
      end
      default: ;
    endcase
`ifdef TSEQ_BRAKE_EN
    if (brake_q) begin
      case (state)
        IDLE: begin
          lamp_l = '1;
          lamp_r = '1;
        end
        LEFT:    lamp_r = '1;
        RIGHT:   lamp_l = '1;
        default: ;
      endcase
    end
`endif
  end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Directed self-checking bench for turn_signal_seq.
// Three instances cover the (NLAMP,TICK_DIV) configurations (3,1), (4,3) and (3,2);
// brake checks are built only when TSEQ_BRAKE_EN is defined.
module tb_turn_signal_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left = 1'b0, right = 1'b0, hazard = 1'b0;
`ifdef TSEQ_BRAKE_EN
  logic brake = 1'b0;
`endif

  logic [2:0] lamp_l_a, lamp_r_a;
  logic       busy_a;
  logic [3:0] lamp_l_b, lamp_r_b;
  logic       busy_b;
  logic [2:0] lamp_l_c, lamp_r_c;
  logic       busy_c;

  int compared = 0;
  int mismatched = 0;
  int busyCount;

  always #5 clk = ~clk;

  turn_signal_seq #(.NLAMP(3), .TICK_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TSEQ_BRAKE_EN
    .brake(brake),
`endif
    .lamp_l(lamp_l_a), .lamp_r(lamp_r_a), .busy(busy_a));

  turn_signal_seq #(.NLAMP(4), .TICK_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TSEQ_BRAKE_EN
    .brake(brake),
`endif
    .lamp_l(lamp_l_b), .lamp_r(lamp_r_b), .busy(busy_b));

  turn_signal_seq #(.NLAMP(3), .TICK_DIV(2)) dut_c (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TSEQ_BRAKE_EN
    .brake(brake),
`endif
    .lamp_l(lamp_l_c), .lamp_r(lamp_r_c), .busy(busy_c));

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Drop all requests, pulse reset, check the dark reset state, then release.
  task automatic applyStimulus();
    left = 0; right = 0; hazard = 0;
`ifdef TSEQ_BRAKE_EN
    brake = 0;
`endif
    reset = 1;
    stepClk();
    stepClk();
    checkOutput("rst_a", {busy_a, lamp_l_a, lamp_r_a}, 0);
    checkOutput("rst_b", {busy_b, lamp_l_b, lamp_r_b}, 0);
    checkOutput("rst_c", {busy_c, lamp_l_c, lamp_r_c}, 0);
    reset = 0;
  endtask

  logic [2:0] expL [8];

  initial begin
    // Left held continuously on (3,1): period 4, right side dark.
    expL = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
    applyStimulus();
    left = 1;
    checkOutput("first_cycle_dark", {busy_a, lamp_l_a}, 0);
    for (int i = 0; i < 8; i++) begin
      stepClk();
      checkOutput($sformatf("left_sweep_l[%0d]", i), lamp_l_a, expL[i]);
      checkOutput($sformatf("left_sweep_r[%0d]", i), lamp_r_a, 0);
      checkOutput($sformatf("left_sweep_busy[%0d]", i), busy_a, (i % 4) != 3);
    end

    // One-cycle right pulse on (4,3): each step held 3 cycles, busy for 12.
    applyStimulus();
    right = 1;
    busyCount = 0;
    for (int i = 0; i < 14; i++) begin
      stepClk();
      if (i == 0) right = 0;
      if (busy_b) busyCount++;
      checkOutput($sformatf("right_div3_r[%0d]", i), lamp_r_b,
                  (i < 12) ? ((32'd1 << (i / 3 + 1)) - 1) : 32'd0);
      checkOutput($sformatf("right_div3_l[%0d]", i), lamp_l_b, 0);
    end
    checkOutput("right_div3_busy_cycles", busyCount, 12);

    // left & right together, then hazard alone: both sides identical.
    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus();
      if (pass == 0) begin left = 1; right = 1; end
      else hazard = 1;
      for (int i = 0; i < 3; i++) begin
        stepClk();
        checkOutput($sformatf("haz%0d_l[%0d]", pass, i), lamp_l_a, (32'd1 << (i + 1)) - 1);
        checkOutput($sformatf("haz%0d_r[%0d]", pass, i), lamp_r_a, (32'd1 << (i + 1)) - 1);
      end
    end

    // Right raised mid-left-sweep: left completes, then HAZ (left held) or RIGHT.
    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus();
      left = 1;
      stepClk();
      stepClk();
      checkOutput($sformatf("mid%0d_step2", pass), lamp_l_a, 3'b011);
      right = 1;
      if (pass == 1) left = 0;
      stepClk();
      checkOutput($sformatf("mid%0d_left_done_l", pass), lamp_l_a, 3'b111);
      checkOutput($sformatf("mid%0d_left_done_r", pass), lamp_r_a, 3'b000);
      stepClk();
      checkOutput($sformatf("mid%0d_idle", pass), {busy_a, lamp_l_a, lamp_r_a}, 0);
      stepClk();
      checkOutput($sformatf("mid%0d_next_l", pass), lamp_l_a, (pass == 0) ? 3'b001 : 3'b000);
      checkOutput($sformatf("mid%0d_next_r", pass), lamp_r_a, 3'b001);
    end

    // Reset at step 2 of a HAZ sweep on (3,2), then restart with a full hold.
    applyStimulus();
    hazard = 1;
    stepClk();
    hazard = 0;
    checkOutput("c_haz_step1", {lamp_l_c, lamp_r_c}, 6'b001_001);
    stepClk();
    checkOutput("c_haz_step1_hold", {lamp_l_c, lamp_r_c}, 6'b001_001);
    stepClk();
    checkOutput("c_haz_step2", {lamp_l_c, lamp_r_c}, 6'b011_011);
    reset = 1;
    #1;
    checkOutput("c_async_reset", {busy_c, lamp_l_c, lamp_r_c}, 0);
    stepClk();
    reset = 0;
    hazard = 1;
    stepClk();
    hazard = 0;
    checkOutput("c_restart_1a", {busy_c, lamp_l_c, lamp_r_c}, 7'b1_001_001);
    stepClk();
    checkOutput("c_restart_1b", {busy_c, lamp_l_c, lamp_r_c}, 7'b1_001_001);
    stepClk();
    checkOutput("c_restart_2", {busy_c, lamp_l_c, lamp_r_c}, 7'b1_011_011);

`ifdef TSEQ_BRAKE_EN
    // Brake with left: right side solid while left sweeps; idle shows both solid.
    applyStimulus();
    brake = 1;
    left = 1;
    stepClk();
    left = 0;
    checkOutput("brk_left_1", {lamp_l_a, lamp_r_a}, 6'b001_111);
    stepClk();
    checkOutput("brk_left_2", {lamp_l_a, lamp_r_a}, 6'b011_111);
    stepClk();
    checkOutput("brk_left_3", {lamp_l_a, lamp_r_a}, 6'b111_111);
    stepClk();
    checkOutput("brk_idle", {busy_a, lamp_l_a, lamp_r_a}, 7'b0_111_111);
    // Brake during hazard is ignored.
    applyStimulus();
    brake = 1;
    hazard = 1;
    stepClk();
    checkOutput("brk_haz_1", {lamp_l_a, lamp_r_a}, 6'b001_001);
    stepClk();
    checkOutput("brk_haz_2", {lamp_l_a, lamp_r_a}, 6'b011_011);
    hazard = 0;
    brake = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
